// File: rtl/qerv_pkg.sv
// Shared types for the bufreg2 sequencer: FSM states, access-size codes
// and the Wishbone byte-lane decode.
package qerv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      BUS,
      SHIFT,
      RUN,
      DONE
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Misaligned half/byte lanes simply fall off the top of the 4-bit mask.
   function automatic logic [3:0] wb_sel_dec(input logic [1:0] size, input logic [1:0] lsb);
      logic [3:0] sel;
      case (size)
         SZ_B:    sel = 4'b0001 << lsb;
         SZ_H:    sel = 4'b0011 << lsb;
         SZ_W:    sel = 4'b1111;
         default: sel = 4'b1111;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/qerv_bufreg2_ctrl_if.sv
// Wishbone data-bus signals between the bufreg2 sequencer and memory.
// stb is not carried separately: it is always equal to cyc.
interface qerv_bufreg2_ctrl_if;
   logic       o_wb_cyc;
   logic       o_wb_we;
   logic [3:0] o_wb_sel;
   logic       i_wb_ack;

   modport master (output o_wb_cyc, output o_wb_we, output o_wb_sel, input  i_wb_ack);
   modport slave  (input  o_wb_cyc, input  o_wb_we, input  o_wb_sel, output i_wb_ack);
endinterface

// File: rtl/qerv_pass_cnt.sv
// Pass counter for one 32-bit bit-serial pass of W bits per cycle.
// Reports the current bit position and the last cycle of the pass.
module qerv_pass_cnt #(
   parameter int BITS_PER_CYCLE = 1,
   parameter int LB             = $clog2(BITS_PER_CYCLE)
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   output logic       o_cnt_done,
   output logic [4:0] o_p
);
   localparam int CW = 5 - LB;

   logic [CW-1:0] cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cnt <= '0;
      else if (i_clr)
         cnt <= '0;
      else if (i_en)
         cnt <= cnt + 1'b1;
   end

   assign o_cnt_done = i_en & (cnt == {CW{1'b1}});
   assign o_p        = 5'(cnt) << LB;

endmodule

// File: rtl/qerv_bufreg2_ctrl.sv
// Sequencer for the shared bit-serial buffer used by loads, stores and shifts:
// buffer strobes, Wishbone handshake, shift hold and a one-cycle done pulse.
module qerv_bufreg2_ctrl
   import qerv_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1,
   parameter int LB             = $clog2(BITS_PER_CYCLE)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_mem_op,
   input  logic                     i_store,
   input  logic                     i_shift_op,
   input  logic [1:0]               i_size,
   input  logic [1:0]               i_lsb,
   input  logic                     i_sh_done,
   qerv_bufreg2_ctrl_if.master      wb,
   output logic                     o_init,
   output logic                     o_en,
   output logic                     o_cnt_done,
   output logic                     o_byte_valid,
   output logic                     o_load,
   output logic [1:0]               o_lsb,
   output logic                     o_busy,
   output logic                     o_done
);

   state_t     state, state_nxt;
   logic [1:0] lsb_q, size_q;
   logic       store_q, mem_q, cyc_q;
   logic       accept, in_pass, cnt_done, load, bv;
   logic [4:0] p;

   assign accept  = i_start & (state == IDLE) & (i_mem_op | i_shift_op);
   assign in_pass = (state == INIT) | (state == RUN);

   // Held at zero outside INIT/RUN, so every pass starts from bit 0.
   qerv_pass_cnt #(
      .BITS_PER_CYCLE (BITS_PER_CYCLE),
      .LB             (LB)
   ) u_pass_cnt (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (!in_pass),
      .i_en       (in_pass),
      .o_cnt_done (cnt_done),
      .o_p        (p)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         cyc_q   <= 1'b0;
         lsb_q   <= 2'd0;
         size_q  <= 2'd0;
         store_q <= 1'b0;
         mem_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cyc_q <= (state_nxt == BUS);
         if (accept) begin
            lsb_q   <= i_lsb;
            size_q  <= i_size;
            store_q <= i_store;
            mem_q   <= i_mem_op;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      bv        = 1'b0;
      case (state)
         IDLE: if (accept) state_nxt = INIT;
         INIT: begin
            // Store data is trimmed so rs2 ends up aligned to byte lane lsb.
            if (mem_q & store_q)
               bv = ({1'b0, p} < (6'd32 - {1'b0, lsb_q, 3'b000}));
            else
               bv = 1'b1;
            if (cnt_done) state_nxt = mem_q ? BUS : SHIFT;
         end
         BUS: begin
            if (wb.i_wb_ack) begin
               load      = !store_q;
               state_nxt = store_q ? DONE : RUN;
            end
         end
         SHIFT: if (i_sh_done) state_nxt = RUN;
         RUN: begin
            // Loads stop shifting past the access size so the buffer holds for extension.
            bv = mem_q ? ({2'b00, p} < (7'd8 << size_q)) : 1'b1;
            if (cnt_done) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign o_init       = (state == INIT);
   assign o_en         = in_pass;
   assign o_cnt_done   = cnt_done;
   assign o_byte_valid = bv;
   assign o_load       = load;
   assign o_lsb        = lsb_q;
   assign o_busy       = (state != IDLE);
   assign o_done       = (state == DONE);

   assign wb.o_wb_cyc = cyc_q;
   assign wb.o_wb_we  = cyc_q & store_q;
   assign wb.o_wb_sel = cyc_q ? wb_sel_dec(size_q, lsb_q) : 4'b0000;

endmodule

// File: tb/tb_qerv_bufreg2_ctrl.sv
// Directed bench for qerv_bufreg2_ctrl: a W=1 and a W=4 instance driven by
// one sequence task that records per-cycle activity for comparison.
module tb_qerv_bufreg2_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst_n, start, use4, mem_op, store, shift_op, sh_done, ack;
   logic [1:0] size, lsb;

   always #5 i_clk = ~i_clk;

   qerv_bufreg2_ctrl_if wb1 ();
   qerv_bufreg2_ctrl_if wb4 ();
   assign wb1.i_wb_ack = ack;
   assign wb4.i_wb_ack = ack;

   logic       init1, en1, cd1, bv1, load1, busy1, done1;
   logic       init4, en4, cd4, bv4, load4, busy4, done4;
   logic [1:0] lsbo1, lsbo4;

   qerv_bufreg2_ctrl #(.BITS_PER_CYCLE(1)) u_dut1 (
      .i_clk (i_clk), .i_rst_n (i_rst_n), .i_start (start & !use4),
      .i_mem_op (mem_op), .i_store (store), .i_shift_op (shift_op),
      .i_size (size), .i_lsb (lsb), .i_sh_done (sh_done), .wb (wb1),
      .o_init (init1), .o_en (en1), .o_cnt_done (cd1), .o_byte_valid (bv1),
      .o_load (load1), .o_lsb (lsbo1), .o_busy (busy1), .o_done (done1)
   );

   qerv_bufreg2_ctrl #(.BITS_PER_CYCLE(4)) u_dut4 (
      .i_clk (i_clk), .i_rst_n (i_rst_n), .i_start (start & use4),
      .i_mem_op (mem_op), .i_store (store), .i_shift_op (shift_op),
      .i_size (size), .i_lsb (lsb), .i_sh_done (sh_done), .wb (wb4),
      .o_init (init4), .o_en (en4), .o_cnt_done (cd4), .o_byte_valid (bv4),
      .o_load (load4), .o_lsb (lsbo4), .o_busy (busy4), .o_done (done4)
   );

   logic       m_init, m_en, m_cd, m_bv, m_load, m_busy, m_done, m_cyc, m_we;
   logic [3:0] m_sel;
   logic [1:0] m_lsbo;
   assign m_init = use4 ? init4 : init1;
   assign m_en   = use4 ? en4   : en1;
   assign m_cd   = use4 ? cd4   : cd1;
   assign m_bv   = use4 ? bv4   : bv1;
   assign m_load = use4 ? load4 : load1;
   assign m_busy = use4 ? busy4 : busy1;
   assign m_done = use4 ? done4 : done1;
   assign m_lsbo = use4 ? lsbo4 : lsbo1;
   assign m_cyc  = use4 ? wb4.o_wb_cyc : wb1.o_wb_cyc;
   assign m_we   = use4 ? wb4.o_wb_we  : wb1.o_wb_we;
   assign m_sel  = use4 ? wb4.o_wb_sel : wb1.o_wb_sel;

   int          n_tests = 0, n_fail = 0;
   int          n_init, n_run, n_shift, n_cyc, n_load, n_done, n_cd, lat;
   logic [31:0] bv_init, bv_run;
   logic [3:0]  sel_cap;
   logic        we_cap;
   logic [1:0]  lsb_cap;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Starts one operation and follows it cycle by cycle until the DUT is idle again.
   task automatic run_op(input bit w4, input bit m, input bit st, input bit sh,
                         input logic [1:0] sz, input logic [1:0] ls,
                         input int ack_dly, input int sh_dly, input bit poke);
      bit fin;
      fin = 1'b0;
      n_init = 0; n_run = 0; n_shift = 0; n_cyc = 0; n_load = 0; n_done = 0; n_cd = 0; lat = 0;
      bv_init = '0; bv_run = '0; sel_cap = '0; we_cap = 1'b0;
      use4 = w4; mem_op = m; store = st; shift_op = sh; size = sz; lsb = ls;
      ack = 1'b0; sh_done = (sh_dly == 0);
      start = 1'b1;
      step();
      start = 1'b0;
      lsb_cap = m_lsbo;
      for (int c = 1; c <= 300 && !fin; c++) begin
         start = poke && (c == 3);
         if (poke && c == 3) begin
            mem_op = 1'b1; store = 1'b1; lsb = 2'd3; size = 2'd0;
         end
         if (m_init) begin
            if (n_init < 32) bv_init[n_init] = m_bv;
            n_init++;
         end else if (m_en) begin
            if (n_run < 32) bv_run[n_run] = m_bv;
            n_run++;
         end
         if (m_cd) n_cd++;
         if (m_busy && !m_en && !m_cyc && !m_done) begin
            n_shift++;
            if (n_shift >= sh_dly) sh_done = 1'b1;
         end
         if (m_cyc) begin
            n_cyc++;
            sel_cap = m_sel;
            we_cap  = m_we;
            ack     = (n_cyc == ack_dly + 1);
         end else begin
            ack = 1'b0;
         end
         #1;
         if (m_load) n_load++;
         if (m_done) begin
            n_done++;
            lat = c;
         end
         if (!m_busy) fin = 1'b1;
         else step();
      end
      chk("op_terminates", 32'(fin), 32'd1);
      ack = 1'b0; sh_done = 1'b0; start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      i_rst_n = 1'b0; start = 1'b0; use4 = 1'b0; mem_op = 1'b0; store = 1'b0;
      shift_op = 1'b0; sh_done = 1'b0; ack = 1'b0; size = 2'd0; lsb = 2'd0;
      #3;
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_init", 32'(init1), 32'd0);
      chk("rst_cyc",  32'(wb1.o_wb_cyc), 32'd0);
      chk("rst_sel",  32'(wb1.o_wb_sel), 32'd0);
      chk("rst_done4", 32'(done4), 32'd0);
      step(); step();
      i_rst_n = 1'b1;
      step();

      // Word store, W=1, lsb=0, ack three cycles after cyc.
      run_op(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 3, 0, 1'b0);
      chk("sw_init_len", n_init, 32);
      chk("sw_bv_init",  bv_init, 32'hFFFF_FFFF);
      chk("sw_cyc_len",  n_cyc, 4);
      chk("sw_sel",      32'(sel_cap), 32'hF);
      chk("sw_we",       32'(we_cap), 32'd1);
      chk("sw_load",     n_load, 0);
      chk("sw_run",      n_run, 0);
      chk("sw_cnt_done", n_cd, 1);
      chk("sw_done_cnt", n_done, 1);
      chk("sw_latency",  lat, 37);

      // Byte store, W=1, lsb=2: only the low 16 bit positions shift in.
      run_op(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 0, 0, 1'b0);
      chk("sb_bv_init", bv_init, 32'h0000_FFFF);
      chk("sb_sel",     32'(sel_cap), 32'h4);
      chk("sb_lsb_out", 32'(lsb_cap), 32'd2);
      chk("sb_latency", lat, 34);

      // Half load, W=4, lsb=1, immediate ack.
      run_op(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 0, 0, 1'b0);
      chk("lh_init_len", n_init, 8);
      chk("lh_bv_init",  bv_init, 32'h0000_00FF);
      chk("lh_load",     n_load, 1);
      chk("lh_run_len",  n_run, 8);
      chk("lh_bv_run",   bv_run, 32'h0000_000F);
      chk("lh_sel",      32'(sel_cap), 32'h6);
      chk("lh_we",       32'(we_cap), 32'd0);
      chk("lh_lsb_out",  32'(lsb_cap), 32'd1);
      chk("lh_cnt_done", n_cd, 2);
      chk("lh_latency",  lat, 18);

      // Shift, W=1, buffer done after five SHIFT cycles.
      run_op(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 0, 5, 1'b0);
      chk("sh_shift_len", n_shift, 5);
      chk("sh_run_len",   n_run, 32);
      chk("sh_bv_run",    bv_run, 32'hFFFF_FFFF);
      chk("sh_no_bus",    n_cyc, 0);
      chk("sh_done_cnt",  n_done, 1);
      chk("sh_latency",   lat, 70);

      // Shift with done already high, plus a store request while busy.
      run_op(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 0, 0, 1'b1);
      chk("sh0_shift_len", n_shift, 1);
      chk("sh0_no_bus",    n_cyc, 0);
      chk("sh0_bv_init",   bv_init, 32'hFFFF_FFFF);
      chk("sh0_done_cnt",  n_done, 1);
      chk("sh0_latency",   lat, 66);
      step();
      chk("sh0_idle_after", 32'(busy1), 32'd0);

      // Reset asserted while the bus cycle is open.
      use4 = 1'b0; mem_op = 1'b1; store = 1'b1; shift_op = 1'b0; size = 2'd2; lsb = 2'd0;
      ack = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
         if (wb1.o_wb_cyc) got = 1'b1;
         else step();
      end
      chk("rb_cyc_seen", 32'(got), 32'd1);
      i_rst_n = 1'b0;
      #1;
      chk("rb_cyc_async",  32'(wb1.o_wb_cyc), 32'd0);
      chk("rb_busy_async", 32'(busy1), 32'd0);
      step(); step();
      i_rst_n = 1'b1;
      step();
      chk("rb_idle_after", 32'(busy1), 32'd0);

      // Word load after reset recovery, ack on the third bus cycle.
      run_op(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2, 0, 1'b0);
      chk("lw_load",    n_load, 1);
      chk("lw_cyc_len", n_cyc, 3);
      chk("lw_run_len", n_run, 32);
      chk("lw_bv_run",  bv_run, 32'hFFFF_FFFF);
      chk("lw_sel",     32'(sel_cap), 32'hF);
      chk("lw_we",      32'(we_cap), 32'd0);
      chk("lw_latency", lat, 68);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/qerv_bufreg2_ctrl.md
Name: qerv_bufreg2_ctrl

Overview:
Sequencer for the shared bit-serial data buffer (bufreg2) used by load, store and shift instructions.
- Generates the buffer control strobes: init, en, cnt_done, byte_valid, load.
- Runs the Wishbone data-bus handshake for memory operations.
- Holds the shift phase until the buffer's down-counter reports done.
- Sits between the decoder/state logic and the buffer; reports completion to the core with a one-cycle done pulse.

Parameters:
- BITS_PER_CYCLE, 1, datapath bits per cycle W; legal values 1, 2, 4, 8.
- LB, $clog2(BITS_PER_CYCLE), width helper; never overridden.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle request to begin an operation; ignored unless in IDLE.
- i_mem_op  in  1  operation is a load or store.
- i_store  in  1  with i_mem_op: 1 = store, 0 = load.
- i_shift_op  in  1  operation is a shift.
- i_size  in  2  access size: 0 = byte, 1 = half, 2 = word.
- i_lsb  in  2  address bits [1:0], sampled at i_start.
- i_sh_done  in  1  buffer down-counter wrap (combinational from buffer).
- i_wb_ack  in  1  data-bus acknowledge.
- o_init  out  1  buffer init phase.
- o_en  out  1  buffer shift enable.
- o_cnt_done  out  1  last cycle of a 32-bit pass.
- o_byte_valid  out  1  gates buffer shifting inside a pass.
- o_load  out  1  latch bus read data into buffer.
- o_lsb  out  2  registered i_lsb, driven to the buffer tap select.
- o_wb_cyc  out  1  bus cycle; stb is tied equal to cyc.
- o_wb_we  out  1  write enable.
- o_wb_sel  out  4  byte lane select.
- o_busy  out  1  not IDLE.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, sync release): state IDLE; counter 0; lsb, size and kind registers 0; all outputs 0.
- Pass counter: 5-LB bits. Bit position p = cnt*W. A pass is 32/W cycles. o_cnt_done is high when cnt is at its maximum and the state is INIT or RUN. The counter clears on entry to every pass.
- States:
  - IDLE → INIT on i_start with (i_mem_op | i_shift_op). i_start with neither is ignored.
  - INIT: o_init=1, o_en=1 for 32/W cycles. At o_cnt_done: mem op → BUS; shift → SHIFT.
  - BUS: o_wb_cyc=1 registered, starting the cycle after INIT ends; o_wb_we=i_store. Holds until i_wb_ack.
    - On ack, load: o_load=1 in the ack cycle, → RUN.
    - On ack, store: → DONE.
    - Ack in the first BUS cycle is legal.
  - SHIFT: o_en=0, o_init=0. Stays until i_sh_done=1 (sampled), then → RUN. If i_sh_done is already high on entry, exit after exactly 1 cycle.
  - RUN: o_en=1 for 32/W cycles, → DONE at o_cnt_done.
  - DONE: o_done=1 for one cycle, → IDLE.
- o_byte_valid:
  - INIT, store: 1 while p < 32-8*lsb, so rs2 ends aligned to byte lane lsb.
  - INIT, shift or load: 1 for the whole pass.
  - RUN, load: 1 while p < 8*2^size; 0 afterwards (buffer holds for sign or zero extension).
  - RUN, shift: 1.
  - All other states: 0.
- o_wb_sel, from the registered lsb and size:
  - byte: 1<<lsb.
  - half: 4'b0011<<lsb.
  - word: 4'b1111.
  - Misaligned combinations are not checked; the result is truncated to 4 bits.
- Inputs other than i_sh_done and i_wb_ack are sampled only at accepted i_start.
- Reset mid-operation: immediate return to IDLE; o_wb_cyc drops asynchronously.
- Latency, IDLE to o_done:
  - store: 32/W + 1 + bus wait + 1.
  - load: 32/W + bus cycles + 32/W + 1.
  - shift: 32/W + shift cycles + 32/W + 1.

Decomposition:
- Package qerv_pkg holds:
  - state enum (IDLE, INIT, BUS, SHIFT, RUN, DONE);
  - size encodings SZ_B=0, SZ_H=1, SZ_W=2.
- One sub-module, qerv_pass_cnt: the pass counter with clear, enable, o_cnt_done and bit-position output p.
- The FSM and the byte_valid/wb_sel decode stay in the top module.

Test Plan:
- Word store, W=1, lsb=0, ack 3 cycles after cyc: expect
  - o_init high for 32 cycles with o_byte_valid high throughout;
  - o_wb_cyc=1, we=1, sel=1111 held until ack;
  - o_done 1 cycle after ack.
- Byte store, W=1, lsb=2: expect o_byte_valid high for the first 16 INIT cycles then low; o_wb_sel=0100.
- Half load, W=4, lsb=1, immediate ack:
  - INIT lasts 8 cycles;
  - o_load pulses in the ack cycle;
  - RUN lasts 8 cycles with o_byte_valid high for the first 4 cycles;
  - o_wb_sel=0110; o_wb_we=0.
- Shift, W=1, i_sh_done asserted 5 cycles after SHIFT entry: expect o_en low for 5 cycles, then RUN for 32 cycles, then a single o_done.
- Shift with i_sh_done high on SHIFT entry: expect exactly 1 SHIFT cycle; also check that i_start during busy is ignored.
- i_rst_n pulsed low during BUS with o_wb_cyc=1: expect o_wb_cyc=0 without waiting for a clock edge; IDLE after release; a following i_start runs normally.
